// File: rtl/cluster_mem_responder.sv
// Memory-side responder for the hart cluster request port: fetch/load/store to a req/ack line backend.
// Optional one-entry line buffer shared by loads and fetches: define CLUSTER_RESP_LINEBUF_EN.
//
// state  | meaning
// IDLE   | waiting for a request level; accept cycle decodes and latches it
// REQ    | first backend request cycle, counter cleared
// WAIT   | backend request held, counter running until ack or timeout
// DONE   | one-cycle completion, busy low, error pulse if any
module cluster_mem_responder #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [31:0]  w_cluster_iaddr,
  input  logic [31:0]  w_cluster_daddr,
  input  logic [31:0]  w_cluster_data_wdata,
  input  logic [2:0]   w_cluster_data_ctrl,
  input  logic         w_cluster_iscode,
  input  logic         w_cluster_isread,
  input  logic         w_cluster_iswrite,
  output logic         w_busy,
  output logic [127:0] w_insn_data,
  output logic [127:0] w_data_data,
  output logic         w_resp_err,
  output logic         w_mem_req,
  output logic         w_mem_we,
  output logic [31:0]  w_mem_addr,
  output logic [127:0] w_mem_wdata,
  output logic [15:0]  w_mem_wstrb,
  input  logic         w_mem_ack,
  input  logic [127:0] w_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic         kind_rd, kind_code, we_q, err_q;
  logic [27:0]  line_q;
  logic [15:0]  wstrb_q;
  logic [127:0] wdata_q, data_q, insn_q;

  logic         req_any, sel_wr, sel_rd, sel_code, bad;
  logic [31:0]  sel_addr, wmask;
  logic [1:0]   size;
  logic [3:0]   off;
  logic [15:0]  strb_base, strb_n;
  logic [127:0] lane_n;
  logic         ack_take, tmo;
  logic         lb_hit;
  logic [127:0] lb_rdata;
  logic         unused_ctrl;

  assign unused_ctrl = w_cluster_data_ctrl[2];

  always_comb begin
    sel_wr    = w_cluster_iswrite;
    sel_rd    = !w_cluster_iswrite && w_cluster_isread;
    sel_code  = !w_cluster_iswrite && !w_cluster_isread && w_cluster_iscode;
    req_any   = w_cluster_iswrite || w_cluster_isread || w_cluster_iscode;
    sel_addr  = (w_cluster_iswrite || w_cluster_isread) ? w_cluster_daddr : w_cluster_iaddr;
    size      = w_cluster_data_ctrl[1:0];
    off       = sel_addr[3:0];
    bad       = 1'b0;
    strb_base = 16'h000f;
    wmask     = 32'hffff_ffff;
    if (sel_wr || sel_rd) begin
      case (size)
        2'd1:    bad = off[0];
        2'd2:    bad = |off[1:0];
        2'd3:    bad = 1'b1;
        default: bad = 1'b0;
      endcase
    end
    case (size)
      2'd0: begin strb_base = 16'h0001; wmask = 32'h0000_00ff; end
      2'd1: begin strb_base = 16'h0003; wmask = 32'h0000_ffff; end
      default: begin strb_base = 16'h000f; wmask = 32'hffff_ffff; end
    endcase
    strb_n = strb_base << off;
    lane_n = {96'b0, w_cluster_data_wdata & wmask} << {off, 3'b000};
  end

  assign ack_take = w_mem_ack && ((state == S_REQ) || (state == S_WAIT));
  assign tmo      = (state == S_WAIT) && !w_mem_ack && (cnt == CNT_LAST);

`ifdef CLUSTER_RESP_LINEBUF_EN
  logic         lb_valid;
  logic [27:0]  lb_tag;
  logic [127:0] lb_data;

  assign lb_hit   = lb_valid && (sel_rd || sel_code) && !bad && (lb_tag == sel_addr[31:4]);
  assign lb_rdata = lb_data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lb_valid <= 1'b0;
      lb_tag   <= '0;
      lb_data  <= '0;
    end else if (state == S_IDLE && req_any &&
                 (bad || (sel_wr && lb_tag == sel_addr[31:4]))) begin
      lb_valid <= 1'b0;
    end else if (ack_take && (kind_rd || kind_code)) begin
      lb_valid <= 1'b1;
      lb_tag   <= line_q;
      lb_data  <= w_mem_rdata;
    end else if (tmo) begin
      lb_valid <= 1'b0;
    end
  end
`else
  assign lb_hit   = 1'b0;
  assign lb_rdata = '0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_any) state_n = (bad || lb_hit) ? S_DONE : S_REQ;
      S_REQ:  state_n = w_mem_ack ? S_DONE : S_WAIT;
      S_WAIT: if (w_mem_ack || cnt == CNT_LAST) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      kind_rd   <= 1'b0;
      kind_code <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      line_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      insn_q    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req_any) begin
        kind_rd   <= sel_rd;
        kind_code <= sel_code;
        we_q      <= sel_wr && !bad;
        line_q    <= sel_addr[31:4];
        wstrb_q   <= (sel_wr && !bad) ? strb_n : '0;
        wdata_q   <= (sel_wr && !bad) ? lane_n : '0;
        err_q     <= bad;
        if (bad) begin
          if (sel_rd) data_q <= '0;
        end else if (lb_hit) begin
          if (sel_rd)   data_q <= lb_rdata;
          if (sel_code) insn_q <= lb_rdata;
        end
      end
      if (state == S_REQ) cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;
      // ack wins over a timeout landing in the same cycle
      if (ack_take) begin
        err_q <= 1'b0;
        if (kind_rd)   data_q <= w_mem_rdata;
        if (kind_code) insn_q <= w_mem_rdata;
      end else if (tmo) begin
        err_q <= 1'b1;
        if (kind_rd)   data_q <= '0;
        if (kind_code) insn_q <= '0;
      end
    end
  end

  assign w_busy      = (state == S_REQ) || (state == S_WAIT) || (state == S_IDLE && req_any);
  assign w_mem_req   = (state == S_REQ) || (state == S_WAIT);
  assign w_mem_we    = we_q;
  assign w_mem_addr  = {line_q, 4'b0000};
  assign w_mem_wdata = wdata_q;
  assign w_mem_wstrb = wstrb_q;
  assign w_resp_err  = (state == S_DONE) && err_q;
  assign w_data_data = data_q;
  assign w_insn_data = insn_q;

endmodule

// File: doc/cluster_mem_responder.md
Name: cluster_mem_responder

Overview:
- Memory-side responder that services the single arbitrated request port driven by the hart cluster: instruction fetch, data load, data store.
- Converts cluster request levels into a req/ack backend transaction, then returns 128-bit line data and the busy handshake the selected hart waits on.
- Sits between the cluster and the memory controller/DRAM bridge.
- Generates byte strobes for stores, detects misalignment, and times out a stalled backend.

Parameters:
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)
CNT_W, 11, timeout counter width, must hold TIMEOUT

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
w_cluster_iaddr  in  32  fetch address
w_cluster_daddr  in  32  data address
w_cluster_data_wdata  in  32  store data, LSB-justified
w_cluster_data_ctrl  in  3  [1:0] size 0=B,1=H,2=W (3 illegal); [2] unsigned, ignored here
w_cluster_iscode  in  1  fetch request level
w_cluster_isread  in  1  load request level
w_cluster_iswrite  in  1  store request level
w_busy  out  1  to cluster; low only in IDLE and DONE
w_insn_data  out  128  last fetched line
w_data_data  out  128  last loaded line
w_resp_err  out  1  1-cycle pulse in DONE if misaligned/illegal size/timeout
w_mem_req  out  1  backend request
w_mem_we  out  1  backend write
w_mem_addr  out  32  {addr[31:4],4'b0}
w_mem_wdata  out  128  store data replicated/shifted into byte lane
w_mem_wstrb  out  16  byte enables within line
w_mem_ack  in  1  backend completion, 1 cycle
w_mem_rdata  in  128  line, valid with ack

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counter 0; latched request cleared. An in-flight backend transaction is abandoned; no ack is expected afterwards.
- Request = iswrite | isread | iscode. Priority when several are high: write > read > code.
- Address: daddr for read/write, iaddr for code.
- IDLE: on request, latch kind, address, ctrl and wdata.
  - If a store/load is misaligned (H with a[0]=1; W with a[1:0]!=0) or size==3 → go to DONE with err.
  - Else → REQ.
  - w_busy is combinationally high in the accept cycle.
- REQ: w_mem_req=1 with addr/we/wdata/wstrb stable; counter=0.
  - Same-cycle ack → DONE.
  - Otherwise → WAIT.
- WAIT: w_mem_req held 1; counter increments.
  - On ack → DONE.
  - Counter==TIMEOUT-1 without ack → DONE with err; w_mem_req drops.
- DONE (exactly 1 cycle):
  - w_busy=0.
  - On success: read updates w_data_data, code updates w_insn_data, from rdata latched at ack. Store updates neither.
  - On error: target register is written with 0.
  - err pulses high in this cycle only.
  - → IDLE.
- Requester protocol: request levels must drop in the DONE cycle. A level still high in IDLE is a new request.
- Strobes: base = 1 (B), 3 (H), 15 (W), shifted left by addr[3:0]. Store data is placed at byte lane addr[3:0] (wdata << 8*addr[3:0]); other lanes 0.
- Loads and fetches: wstrb=0, we=0.
- Ack while in IDLE or DONE: ignored.
- Ack in the same cycle the timeout fires: ack wins (success).

Optional Feature:
CLUSTER_RESP_LINEBUF_EN
- Defined: one-entry line buffer (tag = addr[31:4] + valid) shared by loads and fetches.
  - Read/code hit in IDLE → DONE next cycle with no backend access.
  - Miss fills the buffer on ack.
  - Any store whose line matches the tag invalidates it.
  - Reset and error invalidate it.
- Undefined: every load and fetch goes to the backend; no buffer logic.

Test Plan:
- Reset mid-WAIT (RST high 1 cycle) → state IDLE, w_mem_req=0, w_busy=0, outputs 0, next request serviced normally.
- Load daddr=0x8000_0014, ack after 3 WAIT cycles with rdata=0x0123…CDEF → w_mem_addr=0x8000_0010, busy high 5 cycles, w_data_data=rdata in DONE, err=0.
- Store B at daddr=0x8000_0007, wdata=0xA5 → wstrb=0x0080, w_mem_wdata[63:56]=0xA5, all other bytes 0, we=1.
- Store W at daddr=0x8000_0002 → no w_mem_req, DONE next cycle, err=1 for 1 cycle.
- iscode+isread both high → load serviced first. Code served after DONE if still high, w_insn_data updated only then.
- No ack with TIMEOUT=8 → err pulse after 8 WAIT cycles, w_data_data=0. Ack coinciding with the last count → success.
